// File: rtl/regfile_2r1w_sb_pkg.sv
// Shared sizing, types and helpers for the 2-read/1-write register file.
//   DEFAULT_DATA_W   : default register width
//   DEFAULT_NUM_REGS : default architectural register count
//   rf_data_t        : register word at default width
//   rf_sel_t         : register index at default size
//   rf_idx_valid()   : 1 when an index names an implemented register
package cpu_rf_pkg;

    localparam int unsigned DEFAULT_DATA_W   = 16;
    localparam int unsigned DEFAULT_NUM_REGS = 16;
    localparam int unsigned DEFAULT_SEL_W    = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_DATA_W-1:0] rf_data_t;
    typedef logic [DEFAULT_SEL_W-1:0]  rf_sel_t;

    // Indices at or above num_regs exist only for non-power-of-2 sizes.
    function automatic logic rf_idx_valid(input int unsigned idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/regfile_2r1w_sb_if.sv
// Decode/execute-side bus of the register file.
//   Read request : rd_req, rs1_sel, rs2_sel -> stall_o (combinational)
//   Read data    : rs1_o, rs2_o, rd_valid_o (registered)
//   Write        : wr_en, wr_sel, wr_data
//   Scoreboard   : issue_en, issue_sel -> busy_o (registered)
// master = decode/writeback side, slave = register file.
interface regfile_2r1w_sb_if #(
    parameter int unsigned DATA_W   = cpu_rf_pkg::DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS = cpu_rf_pkg::DEFAULT_NUM_REGS
);
    localparam int unsigned SEL_W = $clog2(NUM_REGS);

    logic                rd_req;
    logic [SEL_W-1:0]    rs1_sel;
    logic [SEL_W-1:0]    rs2_sel;
    logic                stall_o;
    logic [DATA_W-1:0]   rs1_o;
    logic [DATA_W-1:0]   rs2_o;
    logic                rd_valid_o;
    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [DATA_W-1:0]   wr_data;
    logic                issue_en;
    logic [SEL_W-1:0]    issue_sel;
    logic [NUM_REGS-1:0] busy_o;

    modport master (
        output rd_req, rs1_sel, rs2_sel, wr_en, wr_sel, wr_data, issue_en, issue_sel,
        input  stall_o, rs1_o, rs2_o, rd_valid_o, busy_o
    );

    modport slave (
        input  rd_req, rs1_sel, rs2_sel, wr_en, wr_sel, wr_data, issue_en, issue_sel,
        output stall_o, rs1_o, rs2_o, rd_valid_o, busy_o
    );

endinterface

// File: rtl/regfile_2r1w_sb_read_port.sv
// One read port: index mux, write-hit compare, hazard term and operand register.
//   sel/regs/busy      : source index, register array, scoreboard
//   wr_en/wr_sel       : write in flight this cycle (wr_data also with REGFILE_BYPASS_EN)
//   load               : request accepted, capture operand at next edge
//   hazard_c           : this source cannot be read this cycle
//   operand_q          : registered operand
// Macro REGFILE_BYPASS_EN forwards same-cycle write data instead of stalling.
module rf_read_port
    import cpu_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter bit          ZERO_REG = 1'b0,
    localparam int unsigned SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [SEL_W-1:0]                 sel,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REGS-1:0]              busy,
    input  logic                             wr_en,
    input  logic [SEL_W-1:0]                 wr_sel,
`ifdef REGFILE_BYPASS_EN
    input  logic [DATA_W-1:0]                wr_data,
`endif
    input  logic                             load,
    output logic                             hazard_c,
    output logic [DATA_W-1:0]                operand_q
);

    logic              readable_c;
    logic              wr_hit_c;
    logic [DATA_W-1:0] operand_c;

    // Hardwired-zero and out-of-range indices read 0 and never hazard.
    assign readable_c = rf_idx_valid(32'(sel), NUM_REGS) && !(ZERO_REG && (sel == '0));
    assign wr_hit_c   = readable_c && wr_en && (wr_sel == sel);

`ifdef REGFILE_BYPASS_EN
    assign hazard_c  = readable_c && busy[sel] && !wr_hit_c;
    assign operand_c = !readable_c ? '0 : (wr_hit_c ? wr_data : regs[sel]);
`else
    // A same-cycle write would make the array value stale: stall one cycle.
    assign hazard_c  = readable_c && (busy[sel] || wr_hit_c);
    assign operand_c = readable_c ? regs[sel] : '0;
`endif

    // Operand register: holds between accepted requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_q <= '0;
        end else if (load) begin
            operand_q <= operand_c;
        end
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file, two registered read ports, one write port, busy scoreboard.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : read request/data, write, issue and busy_o (regfile_2r1w_sb_if.slave)
// Macro REGFILE_BYPASS_EN: reads in the cycle of the producing write are
// accepted with the written value; otherwise they stall one cycle.
module regfile_2r1w_sb
    import cpu_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_2r1w_sb_if.slave   bus
);

    localparam int unsigned SEL_W = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0]             busy_q;
    logic [NUM_REGS-1:0]             busy_d;
    logic                            rd_valid_q;
    logic                            wr_ok_c;
    logic                            issue_ok_c;
    logic                            hazard1_c;
    logic                            hazard2_c;
    logic                            accept_c;

    // Writes/issues to register 0 (when hardwired) or past the end are dropped.
    assign wr_ok_c    = bus.wr_en && rf_idx_valid(32'(bus.wr_sel), NUM_REGS)
                        && !(ZERO_REG && (bus.wr_sel == '0));
    assign issue_ok_c = bus.issue_en && rf_idx_valid(32'(bus.issue_sel), NUM_REGS)
                        && !(ZERO_REG && (bus.issue_sel == '0));

    assign bus.stall_o = bus.rd_req && (hazard1_c || hazard2_c);
    assign accept_c    = bus.rd_req && !bus.stall_o;

    // Register array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else if (wr_ok_c) begin
            regs_q[bus.wr_sel] <= bus.wr_data;
        end
    end

    // Scoreboard: write clears, issue sets; set wins on the same index.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok_c) begin
            busy_d[bus.wr_sel] = 1'b0;
        end
        if (issue_ok_c) begin
            busy_d[bus.issue_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rd_valid_q <= accept_c;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.rd_valid_o = rd_valid_q;

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_port1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (bus.rs1_sel),
        .regs      (regs_q),
        .busy      (busy_q),
        .wr_en     (bus.wr_en),
        .wr_sel    (bus.wr_sel),
`ifdef REGFILE_BYPASS_EN
        .wr_data   (bus.wr_data),
`endif
        .load      (accept_c),
        .hazard_c  (hazard1_c),
        .operand_q (bus.rs1_o)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_port2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (bus.rs2_sel),
        .regs      (regs_q),
        .busy      (busy_q),
        .wr_en     (bus.wr_en),
        .wr_sel    (bus.wr_sel),
`ifdef REGFILE_BYPASS_EN
        .wr_data   (bus.wr_data),
`endif
        .load      (accept_c),
        .hazard_c  (hazard2_c),
        .operand_q (bus.rs2_o)
    );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Directed bench for regfile_2r1w_sb (ZERO_REG=1 build, 16 x 16-bit).
// Driver issues one cycle of stimulus per step and queues the expected
// operand pair of every request it expects to be accepted; the monitor
// pops and compares on each rd_valid_o pulse and checks hold otherwise.
module tb_regfile_2r1w_sb;
    import cpu_rf_pkg::*;

    logic clk;
    logic rst_n;

    regfile_2r1w_sb_if #(.DATA_W(16), .NUM_REGS(16)) rf ();

    regfile_2r1w_sb #(
        .DATA_W   (16),
        .NUM_REGS (16),
        .ZERO_REG (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    rf_data_t    last1 = '0;
    rf_data_t    last2 = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle, driven just after the rising edge.
    task automatic step(input logic rd, input rf_sel_t s1, input rf_sel_t s2,
                        input logic we, input rf_sel_t ws, input rf_data_t wd,
                        input logic ie, input rf_sel_t is,
                        input logic exp_stall, input rf_data_t e1, input rf_data_t e2);
        @(posedge clk);
        #1;
        rf.rd_req    = rd;
        rf.rs1_sel   = s1;
        rf.rs2_sel   = s2;
        rf.wr_en     = we;
        rf.wr_sel    = ws;
        rf.wr_data   = wd;
        rf.issue_en  = ie;
        rf.issue_sel = is;
        #1;
        chk("stall_o", 32'(rf.stall_o), 32'(exp_stall));
        if (rd && !exp_stall) exp_q.push_back({e1, e2});
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    // Monitor: response scoreboard and hold check.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last1 = '0;
            last2 = '0;
            chk("reset_outputs", {15'(0), rf.rd_valid_o, rf.rs1_o ^ rf.rs2_o}, 32'(0));
            chk("reset_rs1", 32'(rf.rs1_o), 32'(0));
        end else if (rf.rd_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", 32'(1), 32'(0));
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("rs1_o", 32'(rf.rs1_o), 32'(e[31:16]));
                chk("rs2_o", 32'(rf.rs2_o), 32'(e[15:0]));
                last1 = e[31:16];
                last2 = e[15:0];
            end
        end else begin
            chk("hold_rs", {rf.rs1_o, rf.rs2_o}, {last1, last2});
        end
    end

    initial begin
        rst_n        = 1'b0;
        rf.rd_req    = 1'b0;
        rf.rs1_sel   = '0;
        rf.rs2_sel   = '0;
        rf.wr_en     = 1'b0;
        rf.wr_sel    = '0;
        rf.wr_data   = '0;
        rf.issue_en  = 1'b0;
        rf.issue_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(rf.busy_o), 32'(0));
        chk("reset_rd_valid", 32'(rf.rd_valid_o), 32'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Reads of reset registers return zero.
        step(1'b1, 4'd3, 4'd5, 1'b0, '0, '0, 1'b0, '0, 1'b0, 16'h0000, 16'h0000);
        // Write r3, then read it; idle cycles hold the operands.
        step(1'b0, '0, '0, 1'b1, 4'd3, 16'hA5A5, 1'b0, '0, 1'b0, '0, '0);
        step(1'b1, 4'd3, 4'd5, 1'b0, '0, '0, 1'b0, '0, 1'b0, 16'hA5A5, 16'h0000);
        idle();
        idle();

        // Producer issued to r7: reads of r7 stall until its write.
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7, 1'b0, '0, '0);
        step(1'b1, 4'd3, 4'd7, 1'b0, '0, '0, 1'b0, '0, 1'b1, '0, '0);
        chk("busy_r7", 32'(rf.busy_o), 32'h0080);
        step(1'b1, 4'd3, 4'd7, 1'b0, '0, '0, 1'b0, '0, 1'b1, '0, '0);
`ifdef REGFILE_BYPASS_EN
        step(1'b1, 4'd3, 4'd7, 1'b1, 4'd7, 16'h1234, 1'b0, '0, 1'b0, 16'hA5A5, 16'h1234);
`else
        step(1'b1, 4'd3, 4'd7, 1'b1, 4'd7, 16'h1234, 1'b0, '0, 1'b1, '0, '0);
`endif
        step(1'b1, 4'd3, 4'd7, 1'b0, '0, '0, 1'b0, '0, 1'b0, 16'hA5A5, 16'h1234);

        // Read of a register written in the same cycle, not busy, both ports.
`ifdef REGFILE_BYPASS_EN
        step(1'b1, 4'd5, 4'd5, 1'b1, 4'd5, 16'hBEEF, 1'b0, '0, 1'b0, 16'hBEEF, 16'hBEEF);
`else
        step(1'b1, 4'd5, 4'd5, 1'b1, 4'd5, 16'hBEEF, 1'b0, '0, 1'b1, '0, '0);
`endif
        step(1'b1, 4'd5, 4'd5, 1'b0, '0, '0, 1'b0, '0, 1'b0, 16'hBEEF, 16'hBEEF);

        // Issue and write to r4 together: busy set wins.
        step(1'b0, '0, '0, 1'b1, 4'd4, 16'h4444, 1'b1, 4'd4, 1'b0, '0, '0);
        step(1'b1, 4'd4, 4'd3, 1'b0, '0, '0, 1'b0, '0, 1'b1, '0, '0);
        chk("busy_r4", 32'(rf.busy_o), 32'h0010);
        step(1'b1, 4'd3, 4'd4, 1'b0, '0, '0, 1'b0, '0, 1'b1, '0, '0);

        // Register 0 hardwired: write and issue ignored, never stalls.
        step(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 1'b0, '0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 4'd0, 4'd0, 1'b0, '0, '0, 1'b1, 4'd0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 4'd0, 4'd0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 16'h0000, 16'h0000);
        chk("busy_r0_ignored", 32'(rf.busy_o), 32'h0010);

        // Reset lands on an accepted read with r2 busy.
        step(1'b1, 4'd3, 4'd5, 1'b0, '0, '0, 1'b1, 4'd2, 1'b0, 16'hA5A5, 16'hBEEF);
        @(posedge clk);
        #1;
        rf.rd_req   = 1'b1;
        rf.rs1_sel  = 4'd3;
        rf.rs2_sel  = 4'd5;
        rf.issue_en = 1'b0;
        #1;
        chk("stall_pre_reset", 32'(rf.stall_o), 32'(0));
        chk("busy_pre_reset", 32'(rf.busy_o), 32'h0014);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rd_valid", 32'(rf.rd_valid_o), 32'(0));
        chk("async_busy", 32'(rf.busy_o), 32'(0));
        chk("async_rs", {rf.rs1_o, rf.rs2_o}, 32'(0));
        rf.rd_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Array cleared by reset.
        step(1'b1, 4'd3, 4'd5, 1'b0, '0, '0, 1'b0, '0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 4'd7, 4'd4, 1'b0, '0, '0, 1'b0, '0, 1'b0, 16'h0000, 16'h0000);
        idle();
        idle();
        idle();
        chk("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
